// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the read/write engines, the arbiter and the SRAM macro wrapper.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
);
    logic              rd_req;
    logic              rd_en;
    logic              rd_last;
    logic [31:0]       rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;
    logic              wr_req;
    logic              wr_en;
    logic              wr_last;
    logic [31:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_gnt;
    logic              CEB;
    logic              WEB;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] DI;
    logic [STRB_W-1:0] BWEB;
    logic [DATA_W-1:0] DO;
    logic              busy;

    modport slave (
        input  rd_req, rd_en, rd_last, rd_addr,
        input  wr_req, wr_en, wr_last, wr_addr, wr_data, wr_strb,
        input  DO,
        output rd_gnt, rd_data, rd_data_vld, wr_gnt,
        output CEB, WEB, A, DI, BWEB, busy
    );

    modport master (
        output rd_req, rd_en, rd_last, rd_addr,
        output wr_req, wr_en, wr_last, wr_addr, wr_data, wr_strb,
        output DO,
        input  rd_gnt, rd_data, rd_data_vld, wr_gnt,
        input  CEB, WEB, A, DI, BWEB, busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Burst-granting arbiter sharing one single-port SRAM between the read and write engines.
// Define SRAM_ARB_RR_EN for round-robin tie breaking; otherwise the write engine wins ties.
module sram_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int STRB_W   = 4,
    parameter int HOLD_MAX = 16
) (
    input logic ACLK,
    input logic ARESETn,
    sram_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_MAX) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic             rd_beat;
    logic             wr_beat;
    logic             hold_exp;
    logic             tie_wr;
    logic             vld_p1;
    logic             unused_addr_bits;

    assign rd_beat  = (state == ST_RD) && bus.rd_en;
    assign wr_beat  = (state == ST_WR) && bus.wr_en;
    assign hold_exp = !rd_beat && !wr_beat && (hold_cnt == CNT_W'(HOLD_MAX - 1));

    assign unused_addr_bits = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                                bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
    // Remembers whether the write engine held the most recent grant.
    logic last_wr;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            last_wr <= 1'b1;
        end else if (state == ST_IDLE && state_nxt == ST_RD) begin
            last_wr <= 1'b0;
        end else if (state == ST_IDLE && state_nxt == ST_WR) begin
            last_wr <= 1'b1;
        end
    end

    assign tie_wr = ~last_wr;
`else
    assign tie_wr = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.rd_req && bus.wr_req) state_nxt = tie_wr ? ST_WR : ST_RD;
                else if (bus.rd_req)          state_nxt = ST_RD;
                else if (bus.wr_req)          state_nxt = ST_WR;
            end
            ST_RD: begin
                if (!bus.rd_req || (rd_beat && bus.rd_last) || hold_exp) state_nxt = ST_IDLE;
            end
            ST_WR: begin
                if (!bus.wr_req || (wr_beat && bus.wr_last) || hold_exp) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: grant state, hold timer and read-return valid.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= rd_beat;
            if (state_nxt != state || rd_beat || wr_beat) begin
                hold_cnt <= '0;
            end else if (state != ST_IDLE) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.rd_gnt      = (state == ST_RD);
    assign bus.wr_gnt      = (state == ST_WR);
    assign bus.busy        = (state == ST_RD) || (state == ST_WR);
    assign bus.rd_data_vld = vld_p1;
    assign bus.rd_data     = vld_p1 ? bus.DO : '0;

    // Macro controls follow the owner's beat strobe in the same cycle.
    always_comb begin
        bus.CEB  = 1'b1;
        bus.WEB  = 1'b1;
        bus.A    = '0;
        bus.DI   = '0;
        bus.BWEB = '1;
        if (rd_beat) begin
            bus.CEB = 1'b0;
            bus.A   = bus.rd_addr[ADDR_W+1:2];
        end else if (wr_beat) begin
            bus.CEB  = 1'b0;
            bus.WEB  = 1'b0;
            bus.A    = bus.wr_addr[ADDR_W+1:2];
            bus.DI   = bus.wr_data;
            bus.BWEB = ~bus.wr_strb;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: expected read data queued at beat issue, popped on rd_data_vld.
module tb_sram_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int HOLD_MAX = 16;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b1;
    always #5 ACLK = ~ACLK;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb_q[$];

    function automatic logic [DATA_W-1:0] do_of(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 | DATA_W'(a);
    endfunction

    // Macro model: read data appears the cycle after a read access.
    always @(posedge ACLK) begin
        if (!bus.CEB && bus.WEB) bus.DO <= do_of(bus.A);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic mon();
        logic [DATA_W-1:0] e;
        if (bus.rd_data_vld) begin
            if (sb_q.size() == 0) begin
                chk("vld_unexp", bus.rd_data_vld, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data", bus.rd_data, e);
            end
        end else begin
            chk("rd_data_idle", bus.rd_data, 0);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
        mon();
    endtask

    task automatic gnt_chk(input string tag, input logic r, input logic w);
        chk({tag, "_rgnt"}, bus.rd_gnt, r);
        chk({tag, "_wgnt"}, bus.wr_gnt, w);
        chk({tag, "_busy"}, bus.busy, r | w);
    endtask

    task automatic bus_chk(input string tag, input logic ceb, input logic web,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] di,
                           input logic [STRB_W-1:0] bweb);
        chk({tag, "_ceb"}, bus.CEB, ceb);
        chk({tag, "_web"}, bus.WEB, web);
        chk({tag, "_a"}, bus.A, a);
        chk({tag, "_di"}, bus.DI, di);
        chk({tag, "_bweb"}, bus.BWEB, bweb);
    endtask

    task automatic clr_in();
        bus.rd_req = 0; bus.rd_en = 0; bus.rd_last = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_en = 0; bus.wr_last = 0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.wr_strb = '0;
    endtask

    task automatic clr_beat();
        bus.rd_en = 0; bus.rd_last = 0; bus.wr_en = 0; bus.wr_last = 0;
    endtask

    // Single last beat by whichever engine currently owns the macro.
    task automatic owner_beat(input logic is_rd, input logic [31:0] addr);
        if (is_rd) begin
            bus.rd_en = 1; bus.rd_last = 1; bus.rd_addr = addr;
            sb_q.push_back(do_of(addr[ADDR_W+1:2]));
        end else begin
            bus.wr_en = 1; bus.wr_last = 1; bus.wr_addr = addr;
            bus.wr_strb = 4'hF; bus.wr_data = 32'h1234_5678;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first_rd;
`ifdef SRAM_ARB_RR_EN
        first_rd = 1'b1;
`else
        first_rd = 1'b0;
`endif
        clr_in();
        ARESETn = 1;
        repeat (3) @(posedge ACLK);
        #1;
        gnt_chk("rst", 0, 0);
        bus_chk("rst", 1, 1, '0, '0, '1);
        chk("rst_vld", bus.rd_data_vld, 0);
        chk("rst_rdata", bus.rd_data, 0);
        ARESETn = 0;

        // strobes with no grant must not touch the macro
        bus.rd_en = 1; bus.rd_addr = 32'h500;
        bus.wr_en = 1; bus.wr_addr = 32'h504; bus.wr_data = 32'hFFFF_FFFF; bus.wr_strb = 4'hF;
        #1;
        bus_chk("idle_strb", 1, 1, '0, '0, '1);
        clr_in();

        // tie twice: first from the reset pointer, then right after release
        bus.rd_req = 1; bus.wr_req = 1;
        cyc();
        gnt_chk("tie1", first_rd, !first_rd);
        owner_beat(first_rd, 32'h300);
        cyc();
        clr_beat();
        gnt_chk("tie1_rel", 0, 0);
        cyc();
        gnt_chk("tie2", 0, 1);
        owner_beat(1'b0, 32'h304);
        cyc();
        clr_in();
        gnt_chk("tie2_rel", 0, 0);
        cyc();
        chk("tie_sb", sb_q.size(), 0);

        // four-beat read burst
        bus.rd_req = 1;
        cyc();
        gnt_chk("rd_gnt", 1, 0);
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1; bus.rd_addr = 32'h100 + 32'(4 * i); bus.rd_last = (i == 3);
            #1;
            bus_chk("rd_beat", 0, 1, ADDR_W'(14'h40 + i), '0, '1);
            sb_q.push_back(do_of(ADDR_W'(14'h40 + i)));
            cyc();
        end
        clr_in();
        gnt_chk("rd_rel", 0, 0);
        cyc();
        chk("rd_sb", sb_q.size(), 0);

        // write burst, last beat with no byte strobes
        bus.wr_req = 1;
        cyc();
        gnt_chk("wr_gnt", 0, 1);
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1; bus.wr_addr = 32'h200 + 32'(4 * i); bus.wr_data = 32'hDEAD_BEEF;
            bus.wr_strb = (i < 2) ? 4'b0011 : 4'b0000; bus.wr_last = (i == 2);
            #1;
            bus_chk("wr_beat", 0, 0, ADDR_W'(14'h80 + i), 32'hDEAD_BEEF,
                    (i < 2) ? 4'b1100 : 4'b1111);
            cyc();
        end
        clr_in();
        gnt_chk("wr_rel", 0, 0);

        // write strobes during a read grant are ignored
        bus.rd_req = 1;
        cyc();
        gnt_chk("rdw_gnt", 1, 0);
        bus.wr_en = 1; bus.wr_strb = 4'hF; bus.wr_data = 32'hAAAA_AAAA; bus.wr_addr = 32'h600;
        #1;
        bus_chk("rdw_only", 1, 1, '0, '0, '1);
        cyc();
        bus.rd_en = 1; bus.rd_last = 1; bus.rd_addr = 32'h400;
        #1;
        bus_chk("rdw_beat", 0, 1, 14'h100, '0, '1);
        sb_q.push_back(do_of(14'h100));
        cyc();
        clr_in();
        gnt_chk("rdw_rel", 0, 0);
        cyc();
        chk("rdw_sb", sb_q.size(), 0);

        // idle reader times out, pending writer follows after one idle cycle
        bus.rd_req = 1;
        cyc();
        bus.wr_req = 1;
        for (int k = 0; k < HOLD_MAX; k++) begin
            gnt_chk("hold", 1, 0);
            cyc();
        end
        gnt_chk("hold_exp", 0, 0);
        cyc();
        gnt_chk("hold_wr", 0, 1);
        bus.rd_req = 0; bus.wr_req = 0;
        cyc();
        gnt_chk("abort", 0, 0);

        // asynchronous reset in the middle of a write beat
        bus.wr_req = 1;
        cyc();
        gnt_chk("rstw_gnt", 0, 1);
        bus.wr_en = 1; bus.wr_strb = 4'hF; bus.wr_addr = 32'h700; bus.wr_data = 32'h55;
        #1;
        bus_chk("rstw_pre", 0, 0, 14'h1C0, 32'h55, 4'h0);
        #2;
        ARESETn = 1;
        #1;
        gnt_chk("rst_mid", 0, 0);
        bus_chk("rst_mid", 1, 1, '0, '0, '1);
        #1;
        ARESETn = 0;
        bus.wr_en = 0;
        cyc();
        gnt_chk("post_rst", 0, 1);
        bus.wr_req = 0;
        cyc();
        gnt_chk("post_rel", 0, 0);

        chk("sb_final", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port SRAM macro between the SRAM slave's read engine and write engine. Each engine requests burst ownership, receives an exclusive grant for the burst, and issues one beat per cycle; the arbiter drives the macro's active-low controls and returns read data with fixed latency. Sits between the AXI slave read/write FSMs and the SRAM macro wrapper.

## Interface
- ADDR_W, 14, SRAM word-address width (A = byte address[ADDR_W+1:2])
- DATA_W, 32, data width
- STRB_W, 4, byte-strobe width
- HOLD_MAX, 16, maximum cycles a grant may be held without a last beat
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-high (asserted = 1)
- rd_req  in  1  read engine requests SRAM ownership
- rd_en  in  1  read beat issue strobe
- rd_last  in  1  current read beat is the last of the burst
- rd_addr  in  32  read byte address
- rd_gnt  out  1  read engine owns SRAM
- rd_data  out  DATA_W  read data
- rd_data_vld  out  1  rd_data valid
- wr_req / wr_en / wr_last  in  1 each  write-side equivalents
- wr_addr  in  32  write byte address
- wr_data  in  DATA_W  write data
- wr_strb  in  STRB_W  byte strobes, active-high
- wr_gnt  out  1  write engine owns SRAM
- CEB  out  1  macro chip enable, active-low
- WEB  out  1  macro write enable, active-low (0 = write)
- A  out  ADDR_W  macro word address
- DI  out  DATA_W  macro write data
- BWEB  out  STRB_W  macro byte write enable, active-low
- DO  in  DATA_W  macro read data, valid cycle after read access
- busy  out  1  a grant is held

## Operation
- States: IDLE, RD, WR. rd_gnt = (state==RD), wr_gnt = (state==WR), busy = rd_gnt|wr_gnt; all registered.
- IDLE: only rd_req -> RD; only wr_req -> WR; both -> per priority policy (Configuration); none -> stay.
- RD: rd_en -> CEB=0, WEB=1, BWEB=all 1, A=rd_addr[ADDR_W+1:2]. rd_en&rd_last -> IDLE.
- WR: wr_en -> CEB=0, WEB=0, A=wr_addr[ADDR_W+1:2], DI=wr_data, BWEB=~wr_strb. wr_en&wr_last -> IDLE. wr_strb=0 still drives CEB=0 with BWEB all 1 (no byte written).
- Owner drops req without last: -> IDLE next cycle (abort).
- Hold counter: cleared on grant entry and on every beat; increments each granted cycle without a beat; reaching HOLD_MAX-1 forces -> IDLE.
- Beat strobes from the non-owner, or any strobe in IDLE, ignored: CEB=1, WEB=1, BWEB all 1, A=0, DI=0.
- Macro outputs combinational from state and owner's beat inputs; no other path.
- Read return: rd_data_vld registered = read access issued previous cycle; rd_data = DO while rd_data_vld, else 0.
- Grant released after a last beat always passes through IDLE one cycle before any new grant.

## Timing
- Reset (async): state IDLE, rd_gnt=wr_gnt=busy=0, CEB=1, WEB=1, BWEB all 1, A=0, DI=0, rd_data=0, rd_data_vld=0, hold counter 0, priority pointer = write-last-granted.
- Request-to-grant: req sampled high in IDLE at edge N -> gnt high after edge N.
- Beat issue: zero latency; CEB low same cycle as en while granted.
- Read latency: rd_en at cycle N -> rd_data_vld=1 with DO in cycle N+1, including the last beat (vld after gnt drops).
- Back-to-back beats: one per cycle, no bubbles inside a burst.
- Minimum release gap: last beat cycle N, gnt low cycle N+1, next grant cycle N+2 at earliest.
- Reset mid-burst: grant, CEB and pending rd_data_vld cleared immediately; burst not resumed.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin on tie; one-bit pointer records last owner, updated on every grant; tie grants the engine not last granted. Reset pointer = write, so first tie grants read.
- Undefined: fixed priority, write wins every tie; pointer logic absent.

## Test plan
- rd_req at cycle 1, 4 rd_en beats addr 0x100..0x10C, last on 4th -> rd_gnt cycles 2-5, A=0x40..0x43, rd_data_vld cycles 3-6 carrying DO, gnt low cycle 6.
- wr_req, 2 beats wr_strb=4'b0011 data 0xDEADBEEF -> CEB=0, WEB=0, BWEB=4'b1100, DI=0xDEADBEEF on both beats; wr_gnt drops after last.
- rd_req and wr_req together twice in succession -> with SRAM_ARB_RR_EN: read then write; without: write both times.
- Granted reader holds rd_req with no rd_en for HOLD_MAX cycles -> forced to IDLE; pending wr_req granted two cycles later.
- wr_en pulsed during RD grant -> CEB follows rd_en only, WEB stays 1.
- ARESETn asserted mid-write-burst between edges -> CEB=1, wr_gnt=0 immediately; after deassert, new wr_req granted normally.
